// File: rtl/led_shift_count_rm.sv
// led_shift_count_rm
// Reconfigurable LED pattern producer for the top-level partition.
//   upper : one-hot "bouncing" shift pattern 0001,0010,0100,1000,0100,0010,...
//   lower : free-running 4-bit counter, wraps modulo 16
// Both advance on a prescaled tick of gclk; upper moves once every
// SHIFT_EVERY ticks. All outputs are driven directly from flops.
// Optional build macro LED_GRAY_EN: when defined, lower shows the Gray
// code of the counter instead of plain binary (same timing).

module led_shift_count_rm #(
    parameter int TICK_DIV    = 10_000_000, // gclk cycles per tick, 1 .. 2^31-1
    parameter int SHIFT_EVERY = 1           // ticks per upper step, 1 .. 255
) (
    input  logic       gclk,
    input  logic       rst,
    output logic [3:0] upper,
    output logic [3:0] lower
);

    // Prescaler is wide enough to hold TICK_DIV-1, never narrower than 1 bit.
    localparam int              PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]       SHIFT_LAST = 8'(SHIFT_EVERY - 1);

    typedef enum logic {
        S_LEFT  = 1'b0,
        S_RIGHT = 1'b1
    } state_t;

    logic [PRE_W-1:0] prescaler;
    logic [7:0]       shift_cnt;
    logic [3:0]       count;
    logic [3:0]       count_nxt;
    logic [3:0]       upper_nxt;
    logic             tick;
    logic             step;
    logic             upper_ok;
    state_t           state;
    state_t           state_nxt;

    // Map the binary count onto the value shown on the lower LEDs.
    function automatic logic [3:0] lower_code(input logic [3:0] c);
`ifdef LED_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    assign tick      = (prescaler == PRE_LAST);
    assign step      = tick && (shift_cnt == SHIFT_LAST);
    assign count_nxt = count + 4'd1;
    // A legal pattern has exactly one LED lit.
    assign upper_ok  = (upper != 4'b0000) && ((upper & (upper - 4'd1)) == 4'b0000);

    // Prescaler: count gclk cycles and restart after TICK_DIV of them.
    // NOTE: every flop here uses a synchronous, active-high reset checked first,
    // so rst wins over any tick or step on the same edge.
    always_ff @(posedge gclk) begin
        // NOTE: sequential state is written with <= so all flops sample the
        // pre-edge values; a blocking = here would chain updates within one edge.
        if (rst)
            prescaler <= '0;
        else if (tick)
            prescaler <= '0;
        else
            prescaler <= prescaler + 1'b1;
    end

    // Step divider: count ticks and raise step every SHIFT_EVERY of them.
    always_ff @(posedge gclk) begin
        if (rst)
            shift_cnt <= 8'd0;
        else if (tick) begin
            if (shift_cnt == SHIFT_LAST)
                shift_cnt <= 8'd0;
            else
                shift_cnt <= shift_cnt + 8'd1;
        end
    end

    // Lower counter and its registered display value, both advanced per tick.
    always_ff @(posedge gclk) begin
        if (rst) begin
            count <= 4'd0;
            lower <= 4'd0;
        end else if (tick) begin
            count <= count_nxt;
            lower <= lower_code(count_nxt);
        end
    end

    // Upper FSM state register, holding both the direction and the pattern.
    always_ff @(posedge gclk) begin
        if (rst) begin
            state <= S_LEFT;
            upper <= 4'b0001;
        end else begin
            state <= state_nxt;
            upper <= upper_nxt;
        end
    end

    // Upper FSM next-state: reverse direction when the pattern hits an end.
    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and
        // no latch is inferred.
        state_nxt = state;
        if (step) begin
            if (!upper_ok) begin
                state_nxt = S_LEFT;
            end else begin
                case (state)
                    // Moving left: the step that lands on 1000 turns us around.
                    S_LEFT:  if (upper[2] || upper[3]) state_nxt = S_RIGHT;
                    // Moving right: the step that lands on 0001 turns us around.
                    S_RIGHT: if (upper[1] || upper[0]) state_nxt = S_LEFT;
                    default: state_nxt = S_LEFT;
                endcase
            end
        end
    end

    // Upper FSM output: shift the lit LED one place on each step.
    always_comb begin
        upper_nxt = upper;
        if (step) begin
            if (!upper_ok) begin
                // Corrupted pattern (SEU or forced value): restart the bounce.
                upper_nxt = 4'b0001;
            end else begin
                case (state)
                    // An end LED seen with the wrong direction bounces back
                    // instead of shifting out to zero.
                    S_LEFT:  upper_nxt = upper[3] ? (upper >> 1) : (upper << 1);
                    S_RIGHT: upper_nxt = upper[0] ? (upper << 1) : (upper >> 1);
                    default: upper_nxt = 4'b0001;
                endcase
            end
        end
    end

endmodule
